// File: rtl/dco_nco.sv
// Phase-accumulator DCO: signed control word -> clamped FCW -> accumulator MSB as pll_clk; DCO_DITHER_EN adds LFSR dither to the FCW LSBs.
// Latency: control captured at edge N, FCW/sat registered at N+1, new phase step applied at N+2.
// No backpressure: ctrl_valid is a strobe or level and every edge accepts; enable=0 parks the phase at 0.
module dco_nco #(
    parameter int ACC_W       = 24,
    parameter int CTRL_W      = 16,
    parameter int FCW_NOM     = 4194304,
    parameter int GAIN_SHIFT  = 5,
    parameter int FCW_MIN     = 3670016,
    parameter int FCW_MAX     = 4718592,
    parameter int DITHER_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     ctrl_valid,
    input  logic signed [CTRL_W-1:0] control,
    output logic                     pll_clk,
    output logic                     wrap,
    output logic [ACC_W-1:0]         fcw_out,
    output logic                     sat
);

    // Wide enough that neither the shifted control nor the nominal offset can overflow.
    localparam int SUM_W = ACC_W + CTRL_W + GAIN_SHIFT + 1;
    localparam logic signed [SUM_W-1:0] NOM_S = SUM_W'(FCW_NOM);
    localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(FCW_MIN);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(FCW_MAX);

    logic signed [CTRL_W-1:0] ctrl_q;
    logic signed [SUM_W-1:0]  ctrl_ext;
    logic signed [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         fcw_eff;
    logic [ACC_W:0]           acc_sum;
    logic [DITHER_BITS-1:0]   dither;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (ctrl_valid) begin
            ctrl_q <= control;
        end
    end

    always_comb begin
        ctrl_ext = {{(SUM_W-CTRL_W){ctrl_q[CTRL_W-1]}}, ctrl_q};
        sum      = NOM_S + (ctrl_ext <<< GAIN_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_out <= ACC_W'(FCW_NOM);
            sat     <= 1'b0;
        end else if (sum > MAX_S) begin
            fcw_out <= ACC_W'(FCW_MAX);
            sat     <= 1'b1;
        end else if (sum < MIN_S) begin
            fcw_out <= ACC_W'(FCW_MIN);
            sat     <= 1'b1;
        end else begin
            fcw_out <= sum[ACC_W-1:0];
            sat     <= 1'b0;
        end
    end

`ifdef DCO_DITHER_EN
    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; only runs while the oscillator runs.
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (enable) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign dither = lfsr[DITHER_BITS-1:0];
`else
    assign dither = '0;
`endif

    // Dither is added after the clamp on purpose: fcw_out always reports the undithered word.
    assign fcw_eff = fcw_out + ACC_W'(dither);
    assign acc_sum = {1'b0, acc} + {1'b0, fcw_eff};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            wrap    <= 1'b0;
            pll_clk <= 1'b0;
        end else if (!enable) begin
            acc     <= '0;
            wrap    <= 1'b0;
            pll_clk <= 1'b0;
        end else begin
            acc     <= acc_sum[ACC_W-1:0];
            wrap    <= acc_sum[ACC_W];
            pll_clk <= acc_sum[ACC_W-1];
        end
    end

endmodule
